// File: rtl/wav_dfi_phy_resp_pkg.sv
// wav_dfi_phy_resp_pkg: FSM states, phyupd type codes and default handshake timing for the DFI PHY responder
package wav_dfi_phy_resp_pkg;

    typedef enum logic [1:0] {LP_IDLE, LP_WAIT, LP_ACK} lp_state_e;
    typedef enum logic [1:0] {CU_IDLE, CU_WAIT, CU_ACK} cu_state_e;
    typedef enum logic [1:0] {PU_IDLE, PU_REQ, PU_HOLD, PU_DROP} pu_state_e;

    localparam logic [1:0] PHYUPD_TYPE0 = 2'd0;
    localparam logic [1:0] PHYUPD_TYPE1 = 2'd1;
    localparam logic [1:0] PHYUPD_TYPE2 = 2'd2;
    localparam logic [1:0] PHYUPD_TYPE3 = 2'd3;

    typedef struct packed {
        logic [3:0] lp_ack_dly;
        logic [3:0] ctrlupd_ack_dly;
        logic [7:0] init_dly;
        logic [7:0] tphyupd_resp;
        logic [7:0] phyupd_hold;
    } timing_t;

    localparam timing_t DFLT_TIMING = '{
        lp_ack_dly:      4'd4,
        ctrlupd_ack_dly: 4'd2,
        init_dly:        8'd16,
        tphyupd_resp:    8'd32,
        phyupd_hold:     8'd8
    };

    // Countdown preload for a wakeup-derived LP delay of min(wakeup+1, 16) cycles.
    function automatic logic [3:0] lp_wakeup_dly_m1(input logic [5:0] wakeup);
        return (wakeup > 6'd15) ? 4'd15 : wakeup[3:0];
    endfunction

endpackage

// File: rtl/wav_dfi_lp_hs.sv
// wav_dfi_lp_hs: one DFI low-power request/acknowledge handshake with a programmable ack delay
module wav_dfi_lp_hs
    import wav_dfi_phy_resp_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       hold_off,
    input  logic [3:0] dly_m1,
    output logic       ack,
    output logic       busy
);

    lp_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ack_q, ack_d;

    // State, countdown and registered acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LP_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    // Accept a request unless held off, count down, abort or release when req falls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LP_IDLE: if (req && !hold_off) begin
                state_d = LP_WAIT;
                cnt_d   = dly_m1;
            end
            LP_WAIT: if (!req) state_d = LP_IDLE;
                     else if (cnt_q == '0) state_d = LP_ACK;
                     else cnt_d = cnt_q - 4'd1;
            LP_ACK:  if (!req) state_d = LP_IDLE;
            default: state_d = LP_IDLE;
        endcase
    end

    // Ack is high for exactly the cycles spent in ACK.
    always_comb ack_d = (state_d == LP_ACK);

    assign ack  = ack_q;
    assign busy = (state_q != LP_IDLE);

endmodule

// File: rtl/wav_dfi_phy_responder.sv
// wav_dfi_phy_responder: PHY-side DFI responder acking lp/ctrlupd/init requests and launching phyupd on command
// Build option: define WAV_DFI_PHY_RESP_WAKEUP_EN to take the LP ack delay from the wakeup code instead of LP_ACK_DLY.
module wav_dfi_phy_responder
    import wav_dfi_phy_resp_pkg::*;
#(
    parameter int LP_ACK_DLY      = int'(DFLT_TIMING.lp_ack_dly),
    parameter int CTRLUPD_ACK_DLY = int'(DFLT_TIMING.ctrlupd_ack_dly),
    parameter int INIT_DLY        = int'(DFLT_TIMING.init_dly),
    parameter int TPHYUPD_RESP    = int'(DFLT_TIMING.tphyupd_resp),
    parameter int PHYUPD_HOLD     = int'(DFLT_TIMING.phyupd_hold)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lp_ctrl_req,
    input  logic [5:0] lp_ctrl_wakeup,
    output logic       lp_ctrl_ack,
    input  logic       lp_data_req,
    input  logic [5:0] lp_data_wakeup,
    output logic       lp_data_ack,
    input  logic       ctrlupd_req,
    output logic       ctrlupd_ack,
    output logic       phyupd_req,
    output logic [1:0] phyupd_type,
    input  logic       phyupd_ack,
    input  logic       init_start,
    output logic       init_complete,
    input  logic       phyupd_start,
    input  logic [1:0] phyupd_start_type,
    output logic       busy,
    output logic       err_phyupd_timeout
);

    logic [3:0] lp_ctrl_dly_m1, lp_data_dly_m1;
    logic       lp_ctrl_busy, lp_data_busy;

`ifdef WAV_DFI_PHY_RESP_WAKEUP_EN
    assign lp_ctrl_dly_m1 = lp_wakeup_dly_m1(lp_ctrl_wakeup);
    assign lp_data_dly_m1 = lp_wakeup_dly_m1(lp_data_wakeup);
`else
    logic unused_wakeup;
    assign unused_wakeup  = ^{lp_ctrl_wakeup, lp_data_wakeup};
    assign lp_ctrl_dly_m1 = 4'(LP_ACK_DLY - 1);
    assign lp_data_dly_m1 = 4'(LP_ACK_DLY - 1);
`endif

    wav_dfi_lp_hs u_lp_ctrl (
        .clock    (clock),
        .reset    (reset),
        .req      (lp_ctrl_req),
        .hold_off (init_start),
        .dly_m1   (lp_ctrl_dly_m1),
        .ack      (lp_ctrl_ack),
        .busy     (lp_ctrl_busy)
    );

    wav_dfi_lp_hs u_lp_data (
        .clock    (clock),
        .reset    (reset),
        .req      (lp_data_req),
        .hold_off (init_start),
        .dly_m1   (lp_data_dly_m1),
        .ack      (lp_data_ack),
        .busy     (lp_data_busy)
    );

    cu_state_e  cu_state_q, cu_state_d;
    logic [3:0] cu_cnt_q, cu_cnt_d;
    logic       cu_ack_q, cu_ack_d;

    pu_state_e  pu_state_q, pu_state_d;
    logic [7:0] pu_cnt_q, pu_cnt_d;
    logic       pu_req_q, pu_req_d;
    logic [1:0] pu_type_q, pu_type_d;
    logic       pu_err_q, pu_err_d;
    logic       pu_go;

    logic       init_prev_q, init_prev_d;
    logic       init_run_q, init_run_d;
    logic       init_done_q, init_done_d;
    logic [7:0] init_cnt_q, init_cnt_d;

    // ctrlupd state, countdown and registered acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            cu_state_q <= CU_IDLE;
            cu_cnt_q   <= '0;
            cu_ack_q   <= 1'b0;
        end else begin
            cu_state_q <= cu_state_d;
            cu_cnt_q   <= cu_cnt_d;
            cu_ack_q   <= cu_ack_d;
        end
    end

    // A pending ctrlupd request waits out any phyupd handshake and init before it is taken.
    always_comb begin
        cu_state_d = cu_state_q;
        cu_cnt_d   = cu_cnt_q;
        case (cu_state_q)
            CU_IDLE: if (ctrlupd_req && !init_start && pu_state_q == PU_IDLE) begin
                cu_state_d = CU_WAIT;
                cu_cnt_d   = 4'(CTRLUPD_ACK_DLY - 1);
            end
            CU_WAIT: if (!ctrlupd_req) cu_state_d = CU_IDLE;
                     else if (cu_cnt_q == '0) cu_state_d = CU_ACK;
                     else cu_cnt_d = cu_cnt_q - 4'd1;
            CU_ACK:  if (!ctrlupd_req) cu_state_d = CU_IDLE;
            default: cu_state_d = CU_IDLE;
        endcase
    end

    // Registered ack level; the port is gated by req so it drops in the same cycle req does.
    always_comb cu_ack_d = (cu_state_d == CU_ACK);

    assign ctrlupd_ack = cu_ack_q & ctrlupd_req;

    // phyupd state, shared timeout/hold counter, request, type and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            pu_state_q <= PU_IDLE;
            pu_cnt_q   <= '0;
            pu_req_q   <= 1'b0;
            pu_type_q  <= PHYUPD_TYPE0;
            pu_err_q   <= 1'b0;
        end else begin
            pu_state_q <= pu_state_d;
            pu_cnt_q   <= pu_cnt_d;
            pu_req_q   <= pu_req_d;
            pu_type_q  <= pu_type_d;
            pu_err_q   <= pu_err_d;
        end
    end

    // A launch is only taken while ctrlupd stays idle this cycle, so ctrlupd wins a same-cycle collision.
    always_comb begin
        pu_go      = phyupd_start && !init_start && cu_state_q == CU_IDLE && cu_state_d == CU_IDLE;
        pu_state_d = pu_state_q;
        pu_cnt_d   = pu_cnt_q;
        case (pu_state_q)
            PU_IDLE: if (pu_go) begin
                pu_state_d = PU_REQ;
                pu_cnt_d   = '0;
            end
            PU_REQ:  if (phyupd_ack) begin
                pu_state_d = PU_HOLD;
                pu_cnt_d   = '0;
            end else if (pu_cnt_q == 8'(TPHYUPD_RESP - 1)) pu_state_d = PU_DROP;
            else pu_cnt_d = pu_cnt_q + 8'd1;
            PU_HOLD: if (pu_cnt_q == 8'(PHYUPD_HOLD - 1)) pu_state_d = PU_DROP;
                     else pu_cnt_d = pu_cnt_q + 8'd1;
            PU_DROP: if (!phyupd_ack) pu_state_d = PU_IDLE;
            default: pu_state_d = PU_IDLE;
        endcase
    end

    // Request follows REQ/HOLD; type is latched at launch and held until back in IDLE.
    always_comb begin
        pu_req_d  = (pu_state_d == PU_REQ) || (pu_state_d == PU_HOLD);
        pu_type_d = (pu_state_q == PU_IDLE && pu_state_d == PU_REQ) ? phyupd_start_type :
                    (pu_state_d == PU_IDLE) ? PHYUPD_TYPE0 : pu_type_q;
        pu_err_d  = pu_err_q || (pu_state_q == PU_REQ && pu_state_d == PU_DROP);
    end

    assign phyupd_req         = pu_req_q;
    assign phyupd_type        = pu_type_q;
    assign err_phyupd_timeout = pu_err_q;

    // init edge detector, countdown and completion flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            init_prev_q <= 1'b0;
            init_run_q  <= 1'b0;
            init_done_q <= 1'b0;
            init_cnt_q  <= '0;
        end else begin
            init_prev_q <= init_prev_d;
            init_run_q  <= init_run_d;
            init_done_q <= init_done_d;
            init_cnt_q  <= init_cnt_d;
        end
    end

    // Every rise of init_start restarts the countdown; completion does not depend on init_start staying high.
    always_comb begin
        init_prev_d = init_start;
        init_run_d  = init_run_q;
        init_done_d = init_done_q;
        init_cnt_d  = init_cnt_q;
        if (init_start && !init_prev_q) begin
            init_run_d  = 1'b1;
            init_done_d = 1'b0;
            init_cnt_d  = 8'(INIT_DLY - 1);
        end else if (init_run_q) begin
            if (init_cnt_q == '0) begin
                init_run_d  = 1'b0;
                init_done_d = 1'b1;
            end else begin
                init_cnt_d = init_cnt_q - 8'd1;
            end
        end
    end

    assign init_complete = init_done_q;

    assign busy = lp_ctrl_busy | lp_data_busy | (cu_state_q != CU_IDLE) | (pu_state_q != PU_IDLE);

endmodule

// File: tb/tb_wav_dfi_phy_responder.sv
// tb_wav_dfi_phy_responder: scoreboard bench for the DFI PHY responder handshakes
module tb_wav_dfi_phy_responder;

`ifdef WAV_DFI_PHY_RESP_WAKEUP_EN
    localparam int LPD = 10;
`else
    localparam int LPD = 4;
`endif

    localparam logic [8:0] M_LPC  = 9'h001;
    localparam logic [8:0] M_LPD  = 9'h002;
    localparam logic [8:0] M_CU   = 9'h004;
    localparam logic [8:0] M_PREQ = 9'h008;
    localparam logic [8:0] M_TYPE = 9'h030;
    localparam logic [8:0] M_INIT = 9'h040;
    localparam logic [8:0] M_BUSY = 9'h080;
    localparam logic [8:0] M_ERR  = 9'h100;
    localparam logic [8:0] M_ALL  = 9'h1ff;

    logic       clock = 1'b0;
    logic       reset;
    logic       lp_ctrl_req, lp_data_req, ctrlupd_req, phyupd_ack, init_start, phyupd_start;
    logic [5:0] lp_ctrl_wakeup, lp_data_wakeup;
    logic [1:0] phyupd_start_type;
    logic       lp_ctrl_ack, lp_data_ack, ctrlupd_ack, phyupd_req, init_complete, busy, err_phyupd_timeout;
    logic [1:0] phyupd_type;

    typedef struct {
        string      tag;
        int         k;
        logic [8:0] val;
        logic [8:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    wav_dfi_phy_responder #(
        .LP_ACK_DLY      (4),
        .CTRLUPD_ACK_DLY (2),
        .INIT_DLY        (16),
        .TPHYUPD_RESP    (32),
        .PHYUPD_HOLD     (8)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .lp_ctrl_req        (lp_ctrl_req),
        .lp_ctrl_wakeup     (lp_ctrl_wakeup),
        .lp_ctrl_ack        (lp_ctrl_ack),
        .lp_data_req        (lp_data_req),
        .lp_data_wakeup     (lp_data_wakeup),
        .lp_data_ack        (lp_data_ack),
        .ctrlupd_req        (ctrlupd_req),
        .ctrlupd_ack        (ctrlupd_ack),
        .phyupd_req         (phyupd_req),
        .phyupd_type        (phyupd_type),
        .phyupd_ack         (phyupd_ack),
        .init_start         (init_start),
        .init_complete      (init_complete),
        .phyupd_start       (phyupd_start),
        .phyupd_start_type  (phyupd_start_type),
        .busy               (busy),
        .err_phyupd_timeout (err_phyupd_timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] obs();
        return {err_phyupd_timeout, busy, init_complete, phyupd_type, phyupd_req, ctrlupd_ack, lp_data_ack, lp_ctrl_ack};
    endfunction

    function automatic logic [8:0] mk(input logic err, input logic bsy, input logic init, input logic [1:0] typ,
                                      input logic preq, input logic cu, input logic lpd, input logic lpc);
        return {err, bsy, init, typ, preq, cu, lpd, lpc};
    endfunction

    task automatic push(input string tag, input int k, input logic [8:0] val, input logic [8:0] mask);
        exp_t e;
        e.tag  = tag;
        e.k    = k;
        e.val  = val;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; lp_ctrl_req = 1'b0; lp_data_req = 1'b0; ctrlupd_req = 1'b0; phyupd_ack = 1'b0;
        init_start = 1'b0; phyupd_start = 1'b0; phyupd_start_type = 2'b00;
        lp_ctrl_wakeup = 6'd9; lp_data_wakeup = 6'd9;
    endtask

    task automatic settle(input int n);
        idle_inputs();
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 5; k++) push("reset", k, 9'h000, M_ALL);
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            reset = (k < 3);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_lp_ctrl();
        exp_t e;
        for (int k = 0; k < LPD + 9; k++)
            push("lp_ctrl", k, mk(0, k < LPD + 6, 0, 2'b00, 0, 0, 0, k >= LPD && k < LPD + 6), M_LPC | M_LPD | M_BUSY);
        for (int k = 0; k < LPD + 9; k++) begin
            lp_ctrl_req = (k < LPD + 6);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_lp_abort();
        exp_t e;
        for (int k = 0; k < 8; k++) push("lp_data_abort", k, mk(0, k < 2, 0, 2'b00, 0, 0, 0, 0), M_LPC | M_LPD | M_BUSY);
        for (int k = 0; k < 8; k++) begin
            lp_data_req = (k < 2);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_lp_independent();
        exp_t e;
        for (int k = 0; k < LPD + 10; k++)
            push("lp_indep", k, mk(0, 0, 0, 2'b00, 0, 0, k >= LPD + 2 && k < LPD + 8, k >= LPD && k < LPD + 4), M_LPC | M_LPD);
        for (int k = 0; k < LPD + 10; k++) begin
            lp_ctrl_req = (k < LPD + 4);
            lp_data_req = (k >= 2 && k < LPD + 8);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_ctrlupd();
        exp_t e;
        for (int k = 0; k < 9; k++) push("ctrlupd", k, mk(0, k < 6, 0, 2'b00, 0, k >= 2 && k < 6, 0, 0), M_CU | M_PREQ | M_BUSY);
        for (int k = 0; k < 9; k++) begin
            ctrlupd_req = (k < 6);
            if (k == 6) begin
                #2;
                vectors++;
                if (ctrlupd_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL ctrlupd_gate k=6 got %b exp 0", ctrlupd_ack);
                end
            end
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_phyupd_ack();
        exp_t e;
        for (int k = 0; k < 15; k++)
            push("phyupd_ack", k, mk(0, k <= 11, 0, (k <= 11) ? 2'b01 : 2'b00, k <= 10, 0, 0, 0), M_PREQ | M_TYPE | M_BUSY | M_ERR);
        for (int k = 0; k < 15; k++) begin
            phyupd_start      = (k == 0);
            phyupd_start_type = (k == 0) ? 2'b01 : 2'b10;
            phyupd_ack        = (k >= 3 && k <= 11);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_phyupd_timeout();
        exp_t e;
        for (int k = 0; k < 36; k++)
            push("phyupd_timeout", k, mk(k >= 32, k <= 32, 0, (k <= 32) ? 2'b10 : 2'b00, k <= 31, 0, 0, 0), M_PREQ | M_TYPE | M_BUSY | M_ERR);
        for (int k = 0; k < 36; k++) begin
            phyupd_start      = (k == 0);
            phyupd_start_type = (k == 0) ? 2'b10 : 2'b01;
            phyupd_ack        = 1'b0;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        for (int k = 0; k < 9; k++)
            push("collision", k, mk(1, k < 6, 0, 2'b00, 0, k >= 2 && k < 6, 0, 0), M_CU | M_PREQ | M_TYPE | M_BUSY | M_ERR);
        for (int k = 0; k < 9; k++) begin
            ctrlupd_req       = (k < 6);
            phyupd_start      = (k == 0);
            phyupd_start_type = 2'b11;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 18; k++)
            push("holdoff", k, mk(1, k <= 9 || (k >= 11 && k <= 15), 0, 2'b00, k <= 8, k >= 13 && k <= 15, 0, 0),
                 M_CU | M_PREQ | M_BUSY | M_ERR);
        for (int k = 0; k < 18; k++) begin
            phyupd_start      = (k == 0);
            phyupd_start_type = 2'b00;
            phyupd_ack        = (k >= 1 && k <= 9);
            ctrlupd_req       = (k >= 2 && k <= 15);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_init();
        exp_t e;
        for (int k = 0; k < LPD + 24; k++)
            push("init", k, mk(0, k >= 20 && k < LPD + 22, k >= 16, 2'b00, 0, 0, 0, k >= LPD + 20 && k < LPD + 22),
                 M_LPC | M_INIT | M_BUSY);
        for (int k = 0; k < LPD + 24; k++) begin
            init_start  = (k < 20);
            lp_ctrl_req = (k >= 5 && k < LPD + 22);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_init_restart();
        exp_t e;
        for (int k = 0; k < 25; k++) push("init_restart", k, mk(0, 0, k >= 22, 2'b00, 0, 0, 0, 0), M_INIT);
        for (int k = 0; k < 25; k++) begin
            init_start = (k < 3) || (k >= 6 && k < 10);
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int k = 0; k < LPD + 5; k++)
            push("reset_mid", k, (k < LPD + 2) ? mk(1, 1, 1, 2'b11, 1, 0, 0, k >= LPD) : 9'h000, M_ALL);
        for (int k = 0; k < LPD + 5; k++) begin
            reset             = (k == LPD + 2);
            lp_ctrl_req       = (k < LPD + 2);
            phyupd_start      = (k == 0);
            phyupd_start_type = 2'b11;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp %b", e.tag, e.k, obs() & e.mask, e.val & e.mask);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_lp_ctrl();
        settle(3);
        test_lp_abort();
        settle(3);
        test_lp_independent();
        settle(3);
        test_ctrlupd();
        settle(3);
        test_phyupd_ack();
        settle(3);
        test_phyupd_timeout();
        settle(3);
        test_collision();
        settle(3);
        test_back_to_back();
        settle(3);
        test_init();
        settle(3);
        test_init_restart();
        settle(3);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wav_dfi_phy_responder.md
Name: wav_dfi_phy_responder

Overview:
- PHY-side responder for the DFI control handshakes; the far end of the MC-side DFI driver/monitor interface.
- Used as a reactive PHY model in DFI agent benches and as a golden reference for handshake timing.
- Acknowledges lp_ctrl, lp_data, ctrlupd and init requests.
- Initiates phyupd requests on command from the sequence layer.

Parameters:
- LP_ACK_DLY, 4: cycles from lp_*_req high to lp_*_ack high (1..15).
- CTRLUPD_ACK_DLY, 2: cycles from ctrlupd_req rise to ctrlupd_ack (1..15).
- INIT_DLY, 16: cycles from init_start rise to init_complete (1..255).
- TPHYUPD_RESP, 32: max cycles phyupd_req waits for phyupd_ack.
- PHYUPD_HOLD, 8: cycles phyupd_req stays high after ack seen.

Ports:
- clock  in  1  DFI clock
- reset  in  1  synchronous, active-high reset
- lp_ctrl_req  in  1  MC low-power control request
- lp_ctrl_wakeup  in  6  wakeup code
- lp_ctrl_ack  out  1  PHY acknowledge
- lp_data_req  in  1  MC low-power data request
- lp_data_wakeup  in  6  wakeup code
- lp_data_ack  out  1  PHY acknowledge
- ctrlupd_req  in  1  MC update request
- ctrlupd_ack  out  1  PHY acknowledge
- phyupd_req  out  1  PHY update request
- phyupd_type  out  2  PHY update type
- phyupd_ack  in  1  MC acknowledge
- init_start  in  1  MC init request
- init_complete  out  1  PHY init done
- phyupd_start  in  1  one-cycle command: launch phyupd
- phyupd_start_type  in  2  type to drive, sampled with phyupd_start
- busy  out  1  any handshake in progress
- err_phyupd_timeout  out  1  sticky; set on phyupd ack timeout

Behaviour:
- Reset: all outputs 0; all FSMs to IDLE; counters 0. Reset takes effect at the next clock edge, including mid-handshake.
- LP FSM: one instance each for lp_ctrl and lp_data. States IDLE, WAIT, ACK.
  - IDLE->WAIT when req=1 and init_start=0; load counter with LP_ACK_DLY-1.
  - In WAIT, req=0 returns to IDLE with no ack (aborted request).
  - Counter reaching 0 -> ACK; ack is registered high for as long as the FSM is in ACK.
  - ACK->IDLE on the first cycle req=0, so ack is low one cycle after req falls.
- ctrlupd FSM: states IDLE, WAIT, ACK.
  - IDLE->WAIT when ctrlupd_req rises, no phyupd handshake is active, and init_start=0.
  - A request made during phyupd is held off until phyupd returns to IDLE.
  - ctrlupd_ack = ack_q AND ctrlupd_req (combinational gate), so ack is never high without req.
  - ACK->IDLE when req=0.
- phyupd FSM: states IDLE, REQ, HOLD, DROP.
  - phyupd_start is accepted in IDLE only if ctrlupd FSM is IDLE and init_start=0; otherwise it is dropped silently.
  - IDLE->REQ: phyupd_req=1, phyupd_type latched from phyupd_start_type; timeout counter=0.
  - REQ: phyupd_ack=1 -> HOLD. If the counter reaches TPHYUPD_RESP with no ack -> DROP and err_phyupd_timeout=1.
  - HOLD: after PHYUPD_HOLD cycles, deassert phyupd_req -> DROP.
  - DROP: wait phyupd_ack=0 -> IDLE. phyupd_type stays stable until IDLE.
- init:
  - A rise of init_start clears init_complete and starts a counter.
  - init_complete=1 after INIT_DLY cycles, provided init_start is still 1 or has already fallen.
  - A new rise of init_start restarts the counter.
  - While init_start=1, LP and ctrlupd FSMs in IDLE do not leave IDLE.
- busy = OR of (FSM != IDLE) over the four FSMs.
- Simultaneous events:
  - phyupd_start and ctrlupd_req rise in the same cycle: ctrlupd wins and phyupd_start is dropped.
  - lp_ctrl and lp_data run independently.

Optional Feature:
- Macro: WAV_DFI_PHY_RESP_WAKEUP_EN.
- Defined: the LP ack delay is min(wakeup+1, 16) cycles, using the wakeup code sampled with the req rise. LP_ACK_DLY is ignored.
- Undefined: the fixed LP_ACK_DLY is used and the wakeup inputs are unused.

Decomposition:
- Shared package wav_dfi_phy_resp_pkg holds:
  - the FSM state enums for LP, ctrlupd and phyupd;
  - phyupd type constants (TYPE0..TYPE3);
  - a default-timing constants struct.
- Sub-module wav_dfi_lp_hs: one LP handshake FSM with counter, instantiated twice (ctrl, data).

Test Plan:
- lp_ctrl_req held 10 cycles, LP_ACK_DLY=4 -> lp_ctrl_ack high at cycle 4, low at the cycle after req falls.
- lp_data_req pulsed 2 cycles, LP_ACK_DLY=4 -> lp_data_ack never asserts, busy returns to 0.
- ctrlupd_req up 6 cycles, then down -> ack at cycle 2, ack low in the same cycle req falls.
- phyupd_start type=2'b01, MC acks at cycle 3 -> phyupd_req high for 3+8 cycles, phyupd_type=01 throughout, error flag stays 0.
- phyupd_start with no MC ack, TPHYUPD_RESP=32 -> phyupd_req falls at cycle 32, err_phyupd_timeout=1 until reset.
- init_start rise, then lp_ctrl_req asserted at cycle 5 -> init_complete at cycle 16, no lp_ctrl_ack while init_start high; reset mid-phyupd drops all outputs at the next edge.
